spi_mem_slave: RTL and testbench

Word-addressed SPI memory target that serves the CPU core's SPI master port: instruction fetches, data reads and data writes. It samples the master's serial clock, chip select and data lines synchronously in the system clock domain and decodes fixed 33-bit frames. It services each frame from a local 16-bit RAM. A parallel preload port fills program memory before the CPU is released from halt; the bench or system controller drives it.

---
 rtl/spi_mem_slave.sv | 197 +++++++++++++++++++
 tb/tb_spi_mem_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_slave.sv
// spi_mem_slave: word-addressed SPI memory target with a parallel preload port.
// Serial inputs are synchronised into clk. Each 33-bit frame is decoded as
// rwb, then a 16-bit address, then 16-bit data, all MSB first.
module spi_mem_slave #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          sclk_i,
  input  logic          csb_i,
  input  logic          si_i,
  output logic          so_o,
  input  logic          load_en_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [15:0]   load_data_i,
  output logic          busy_o,
  output logic          wr_done_o
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 5;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rwb_q, rwb_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] rx_q, rx_d;
  logic [DW-1:0] tx_q, tx_d;
  logic          seen_q, seen_d;
  logic          rd_req_q, rd_req_d;
  logic          rd_load_q;
  logic          wr_pend_q, wr_req_d;
  logic          so_d, busy_d;
  logic          frame_start, tx_shift;
  logic [DW-1:0] rd_word_q;
  logic [DW-1:0] mem [0:DEPTH-1];

  logic sclk_s1, sclk_s2, sclk_d;
  logic csb_s1, csb_s2, csb_d;
  logic si_s1, si_s2;
  logic sclk_rise, sclk_fall, csb_fall, csb_rise;

  // Two-flop synchronisers plus one delay stage for edge detection
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      csb_s1  <= 1'b0;
      csb_s2  <= 1'b0;
      csb_d   <= 1'b0;
      si_s1   <= 1'b0;
      si_s2   <= 1'b0;
    end else begin
      sclk_s1 <= sclk_i;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      csb_s1  <= csb_i;
      csb_s2  <= csb_s1;
      csb_d   <= csb_s2;
      si_s1   <= si_i;
      si_s2   <= si_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign csb_fall  = ~csb_s2 & csb_d;
  assign csb_rise  = csb_s2 & ~csb_d;

  // Frame decode: next state, bit counting, shift registers and output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rwb_d       = rwb_q;
    addr_d      = addr_q;
    rx_d        = rx_q;
    seen_d      = seen_q;
    rd_req_d    = 1'b0;
    wr_req_d    = 1'b0;
    frame_start = 1'b0;
    tx_shift    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (csb_fall) begin
          state_d     = CMD;
          cnt_d       = '0;
          seen_d      = 1'b0;
          frame_start = 1'b1;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          rwb_d   = si_s2;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (sclk_rise) begin
          // Upper address bits fall off the top, giving modulo-depth wrap
          addr_d = {addr_q[AW-2:0], si_s2};
          cnt_d  = CW'(cnt_q + CW'(1));
          if (cnt_q == CW'(15)) begin
            state_d  = DATA;
            cnt_d    = '0;
            seen_d   = 1'b0;
            rd_req_d = rwb_q;
          end
        end
      end
      DATA: begin
        if (sclk_rise) begin
          rx_d   = {rx_q[DW-2:0], si_s2};
          seen_d = 1'b1;
          cnt_d  = CW'(cnt_q + CW'(1));
          if (cnt_q == CW'(15)) begin
            state_d  = DONE;
            wr_req_d = ~rwb_q;
          end
        end else if (sclk_fall && seen_q) begin
          tx_shift = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Chip-select release aborts any frame
    if (csb_rise) begin
      state_d  = IDLE;
      rd_req_d = 1'b0;
      wr_req_d = 1'b0;
    end

    tx_d = tx_q;
    if (frame_start) begin
      tx_d = '0;
    end else if (rd_load_q) begin
      tx_d = rd_word_q;
    end else if (tx_shift) begin
      tx_d = {tx_q[DW-2:0], 1'b0};
    end
    so_d   = ((state_d == DATA) || (state_d == DONE)) ? tx_d[DW-1] : 1'b0;
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rwb_q     <= 1'b0;
      addr_q    <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      seen_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_load_q <= 1'b0;
      wr_pend_q <= 1'b0;
      so_o      <= 1'b0;
      busy_o    <= 1'b0;
      wr_done_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rwb_q     <= rwb_d;
      addr_q    <= addr_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      seen_q    <= seen_d;
      rd_req_q  <= rd_req_d;
      rd_load_q <= rd_req_q;
      wr_pend_q <= wr_req_d;
      so_o      <= so_d;
      busy_o    <= busy_d;
      wr_done_o <= wr_pend_q;
    end
  end

  // Local RAM: serial write has priority; preload only while no frame is active
  always_ff @(posedge clk) begin
    if (wr_pend_q) begin
      mem[addr_q] <= rx_q;
    end else if (load_en_i && !busy_o) begin
      mem[load_addr_i] <= load_data_i;
    end
    if (rd_req_q) begin
      rd_word_q <= mem[addr_q];
    end
  end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed testbench for spi_mem_slave: drives SPI mode-0 frames and preloads,
// compares serial read data, handshake timing and RAM contents to fixed values.
module tb_spi_mem_slave;

  logic        clk;
  logic        resetb;
  logic        sclk;
  logic        csb;
  logic        si;
  logic        so_o;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [15:0] load_data;
  logic        busy_o;
  logic        wr_done_o;

  int total;
  int bad;
  int wd_total;

  spi_mem_slave #(.AW(10)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .sclk_i     (sclk),
    .csb_i      (csb),
    .si_i       (si),
    .so_o       (so_o),
    .load_en_i  (load_en),
    .load_addr_i(load_addr),
    .load_data_i(load_data),
    .busy_o     (busy_o),
    .wr_done_o  (wr_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every write-commit pulse
  always @(negedge clk) begin
    if (wr_done_o) wd_total <= wd_total + 1;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    clks(1);
    load_en   = 1'b0;
  endtask

  // One sclk cycle: 4 clk low (so_o sampled at the end), 4 clk high
  task automatic spi_bit(input logic b, output logic so_s, output int wd_n);
    wd_n = -1;
    si   = b;
    sclk = 1'b0;
    clks(4);
    so_s = so_o;
    sclk = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (wr_done_o && wd_n < 0) wd_n = n;
    end
    sclk = 1'b0;
  endtask

  // Full or truncated frame; reports read bits, busy latencies and wr_done latency
  task automatic spi_frame(input logic rwb, input logic [15:0] addr, input logic [15:0] wdata,
                           input int ncyc, output logic [15:0] rdata, output logic so_early,
                           output int brise, output int bfall, output int wdlat);
    logic [15:0] a;
    logic [15:0] d;
    logic        b;
    logic        s;
    int          w;
    a = addr;
    d = wdata;
    rdata = '0;
    so_early = 1'b0;
    brise = -1;
    bfall = -1;
    wdlat = -1;
    csb = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (busy_o) begin
        brise = n;
        break;
      end
    end
    for (int i = 0; i < ncyc; i++) begin
      if (i == 0) begin
        b = rwb;
      end else if (i <= 16) begin
        b = a[15];
        a = {a[14:0], 1'b0};
      end else if (i <= 32) begin
        b = d[15];
        d = {d[14:0], 1'b0};
      end else begin
        b = 1'b1;
      end
      spi_bit(b, s, w);
      if (i <= 16) so_early = so_early | s;
      else if (i <= 32) rdata = {rdata[14:0], s};
      if (i == 32) wdlat = w;
    end
    clks(4);
    csb = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (!busy_o) begin
        bfall = n;
        break;
      end
    end
    clks(1);
  endtask

  task automatic test_reset;
    resetb = 1'b0;
    #1;
    total++; if (so_o !== 1'b0) begin bad++; $display("FAIL reset_so got=%b want=0", so_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    total++; if (wr_done_o !== 1'b0) begin bad++; $display("FAIL reset_wr_done got=%b want=0", wr_done_o); end
    clks(3);
    resetb = 1'b1;
    clks(5);
  endtask

  task automatic test_preload_read;
    logic [15:0] r; logic e; int br, bf, wl, w0;
    preload(10'h005, 16'hBEEF);
    clks(2);
    w0 = wd_total;
    spi_frame(1'b1, 16'h0005, 16'h0000, 33, r, e, br, bf, wl);
    total++; if (r !== 16'hBEEF) begin bad++; $display("FAIL preload_read got=%h want=beef", r); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL so_before_data got=%b want=0", e); end
    total++; if (br !== 3) begin bad++; $display("FAIL busy_rise_lat got=%0d want=3", br); end
    total++; if (bf !== 3) begin bad++; $display("FAIL busy_fall_lat got=%0d want=3", bf); end
    total++; if (wd_total - w0 !== 0) begin bad++; $display("FAIL read_no_wr_done got=%0d want=0", wd_total - w0); end
  endtask

  task automatic test_write_read;
    logic [15:0] r; logic e; int br, bf, wl, w0;
    w0 = wd_total;
    spi_frame(1'b0, 16'h0010, 16'h1234, 33, r, e, br, bf, wl);
    total++; if (wl !== 4) begin bad++; $display("FAIL wr_done_lat got=%0d want=4", wl); end
    total++; if (wd_total - w0 !== 1) begin bad++; $display("FAIL wr_done_count got=%0d want=1", wd_total - w0); end
    spi_frame(1'b1, 16'h0010, 16'h0000, 33, r, e, br, bf, wl);
    total++; if (r !== 16'h1234) begin bad++; $display("FAIL write_read got=%h want=1234", r); end
  endtask

  task automatic test_addr_wrap;
    logic [15:0] r; logic e; int br, bf, wl;
    spi_frame(1'b0, 16'h0403, 16'hA5A5, 33, r, e, br, bf, wl);
    spi_frame(1'b1, 16'h0003, 16'h0000, 33, r, e, br, bf, wl);
    total++; if (r !== 16'hA5A5) begin bad++; $display("FAIL addr_wrap got=%h want=a5a5", r); end
  endtask

  task automatic test_abort_write;
    logic [15:0] r; logic e; int br, bf, wl, w0;
    preload(10'h020, 16'h0000);
    clks(2);
    w0 = wd_total;
    spi_frame(1'b0, 16'h0020, 16'hFFFF, 25, r, e, br, bf, wl);
    total++; if (wd_total - w0 !== 0) begin bad++; $display("FAIL abort_wr_done got=%0d want=0", wd_total - w0); end
    total++; if (bf < 1 || bf > 3) begin bad++; $display("FAIL abort_busy_fall got=%0d want=1..3", bf); end
    spi_frame(1'b1, 16'h0020, 16'h0000, 33, r, e, br, bf, wl);
    total++; if (r !== 16'h0000) begin bad++; $display("FAIL abort_ram got=%h want=0000", r); end
  endtask

  task automatic test_preload_blocked;
    logic [15:0] r; logic e; int br, bf, wl;
    preload(10'h040, 16'h1111);
    clks(2);
    csb = 1'b0;
    clks(5);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL busy_during_frame got=%b want=1", busy_o); end
    load_en   = 1'b1;
    load_addr = 10'h040;
    load_data = 16'h2222;
    clks(2);
    load_en = 1'b0;
    csb = 1'b1;
    clks(6);
    spi_frame(1'b1, 16'h0040, 16'h0000, 33, r, e, br, bf, wl);
    total++; if (r !== 16'h1111) begin bad++; $display("FAIL preload_blocked got=%h want=1111", r); end
  endtask

  task automatic test_reset_mid_read;
    logic [15:0] a; logic [15:0] r; logic e, s; int br, bf, wl, w;
    a = 16'h0005;
    csb = 1'b0;
    clks(5);
    spi_bit(1'b1, s, w);
    for (int i = 0; i < 16; i++) begin
      spi_bit(a[15], s, w);
      a = {a[14:0], 1'b0};
    end
    clks(4);
    total++; if (so_o !== 1'b1) begin bad++; $display("FAIL so_before_reset got=%b want=1", so_o); end
    resetb = 1'b0;
    #1;
    total++; if (so_o !== 1'b0) begin bad++; $display("FAIL mid_reset_so got=%b want=0", so_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b want=0", busy_o); end
    clks(2);
    csb = 1'b1;
    clks(2);
    resetb = 1'b1;
    clks(6);
    spi_frame(1'b1, 16'h0005, 16'h0000, 33, r, e, br, bf, wl);
    total++; if (r !== 16'hBEEF) begin bad++; $display("FAIL read_after_reset got=%h want=beef", r); end
  endtask

  task automatic test_extra_clocks;
    logic [15:0] r; logic e; int br, bf, wl, w0;
    w0 = wd_total;
    spi_frame(1'b0, 16'h0100, 16'h5A3C, 35, r, e, br, bf, wl);
    total++; if (wd_total - w0 !== 1) begin bad++; $display("FAIL extra_wr_done got=%0d want=1", wd_total - w0); end
    spi_frame(1'b1, 16'h0100, 16'h0000, 35, r, e, br, bf, wl);
    total++; if (r !== 16'h5A3C) begin bad++; $display("FAIL extra_read got=%h want=5a3c", r); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] r; logic e; int br, bf, wl;
    spi_frame(1'b0, 16'h0007, 16'h0F0F, 33, r, e, br, bf, wl);
    spi_frame(1'b1, 16'h0007, 16'h0000, 33, r, e, br, bf, wl);
    total++; if (r !== 16'h0F0F) begin bad++; $display("FAIL b2b_first got=%h want=0f0f", r); end
    spi_frame(1'b0, 16'h03FF, 16'hC003, 33, r, e, br, bf, wl);
    spi_frame(1'b1, 16'hFFFF, 16'h0000, 33, r, e, br, bf, wl);
    total++; if (r !== 16'hC003) begin bad++; $display("FAIL b2b_second got=%h want=c003", r); end
    total++; if (br !== 3) begin bad++; $display("FAIL b2b_busy_rise got=%0d want=3", br); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    wd_total  = 0;
    sclk      = 1'b0;
    csb       = 1'b1;
    si        = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    resetb    = 1'b0;
    test_reset();
    test_preload_read();
    test_write_read();
    test_addr_wrap();
    test_abort_write();
    test_preload_blocked();
    test_reset_mid_read();
    test_extra_clocks();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
